mips_register_file: RTL and testbench
=====================================

// Module: mips_register_file
// PURPOSE
//   MIPS general-purpose register file: 32 x 32-bit, two combinational read ports, one write port.
//   Instantiated by the instruction-decode stage. Read addresses are driven from instr rs/rt.
//   The single write port is driven by the write-back stage.
//   Register 0 is hard-wired to zero, so no write-enable is needed.
//   Writing address 0 is the "no write" encoding.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of all data ports
//   ADDR_WIDTH  5   register address width (matches REGADDR_WIDTH); depth = 2**ADDR_WIDTH
// PORTS
//   clk         in   1           clock; writes occur on its rising edge
//   rst         in   1           asynchronous, active-low reset (0 = reset asserted)
//   read1_addr  in   ADDR_WIDTH  read port 1 address (rs)
//   read2_addr  in   ADDR_WIDTH  read port 2 address (rt)
//   write_addr  in   ADDR_WIDTH  write address; 0 = no write
//   data_in     in   DATA_WIDTH  write data
//   data_out1   out  DATA_WIDTH  read port 1 data
//   data_out2   out  DATA_WIDTH  read port 2 data
// BEHAVIOUR
//   - Storage: regs[1..31], each DATA_WIDTH bits. regs[0] is not stored and always reads 0.
//   - Reset: rst low immediately (asynchronously) clears regs[1..31] to 0.
//     - While rst is low, no writes occur and both outputs read 0.
//     - Release of rst is clocked normally; the first write can occur at the first rising clk edge after release.
//   - Write: on rising clk edge with rst high and write_addr != 0, regs[write_addr] <= data_in.
//     - write_addr == 0: no state change.
//     - Every cycle with write_addr != 0 is a write; the caller drives 0 to suppress it.
//   - Read: fully combinational, zero latency, independent ports.
//     - addr == 0: output 0 regardless of other inputs.
//     - addr == write_addr and write_addr != 0: output data_in (write-through bypass).
//       This lets ID see the value WB writes in the same cycle.
//     - Otherwise: output regs[addr].
//   - Both ports may read the same address, and both may hit the bypass simultaneously.
//   - No X propagation: all 32 registers are defined after reset. Reads never return X once reset has been applied.
//   - No other state, handshake or stall input; the caller holds values by driving write_addr = 0.
// TESTING
//   - Reset: pulse rst low mid-run after writing r5 = 0x1234_5678.
//     -> data_out for r5 is 0 immediately (asynchronously), before any clk edge.
//   - Write/read: write r3 = 0xDEAD_BEEF, r31 = 0x0000_0001.
//     -> next cycle read1=3, read2=31 give 0xDEAD_BEEF and 0x0000_0001.
//   - Zero register: write_addr = 0, data_in = 0xFFFF_FFFF.
//     -> read1=0 returns 0, and no other register changes.
//   - Bypass: read1=read2=7, write_addr=7, data_in=0xCAFE_0007 in the same cycle.
//     -> both outputs show 0xCAFE_0007 before the edge; r7 holds it afterwards.
//   - Back-to-back writes: write r10 = 1 then r10 = 2 on consecutive cycles.
//     -> reads return 2; r11 is unaffected (0).
//   - Sweep: write r[i] = i * 0x0101_0101 for i = 1..31.
//     -> read all pairs (i, 31 - i) and match; r0 reads 0.

Source files
------------

// File: rtl/mips_register_file.sv
// mips_register_file
// MIPS general-purpose register file: 32 x 32-bit, two combinational read
// ports and one write port. Register 0 is not stored and always reads zero,
// so a write address of 0 doubles as the "no write" encoding. Each read port
// forwards the incoming write data when it addresses the register being
// written, so the decode stage sees a write-back result in the same cycle.

module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read1_addr,
    input  logic [ADDR_WIDTH-1:0] read2_addr,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Flat view of the architectural registers; entry 0 is the constant zero.
    logic [DATA_WIDTH-1:0] w_regs [0:DEPTH-1];

    // Write-through is only possible for a real (non-zero) write address.
    logic w_write_en;

    assign w_write_en = (write_addr != '0);
    assign w_regs[0]  = '0;

    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;
        logic                  w_hit;

        assign w_hit = (write_addr == ADDR_WIDTH'(g));

        // Storage for register g: async clear, loaded when write-back targets it.
        // NOTE: every register is reset (not just left to power-up) so that reads
        // never return X once reset has been applied; state is updated with
        // non-blocking assignments so all flops sample the same pre-edge inputs.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_q <= '0;
            end else if (w_hit) begin
                r_q <= data_in;
            end
        end

        assign w_regs[g] = r_q;
    end

    // Read port 1: zero register, same-cycle bypass, then stored value.
    // NOTE: the output gets a default first so no path through the block can
    // leave it unassigned and infer a latch.
    always_comb begin
        data_out1 = '0;
        if (rst && (read1_addr != '0)) begin
            if (w_write_en && (read1_addr == write_addr)) begin
                data_out1 = data_in;
            end else begin
                data_out1 = w_regs[read1_addr];
            end
        end
    end

    // Read port 2: identical selection, fully independent of port 1.
    always_comb begin
        data_out2 = '0;
        if (rst && (read2_addr != '0)) begin
            if (w_write_en && (read2_addr == write_addr)) begin
                data_out2 = data_in;
            end else begin
                data_out2 = w_regs[read2_addr];
            end
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file
// Directed scenarios followed by randomized traffic, all compared against an
// array-based model of the register file on every falling clock edge, plus
// literal expectations at the key points of each directed scenario.

module tb_mips_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  read1_addr = '0;
    logic [4:0]  read2_addr = '0;
    logic [4:0]  write_addr = '0;
    logic [31:0] data_in    = '0;
    logic [31:0] data_out1;
    logic [31:0] data_out2;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural contents as the programmer sees them.
    logic [31:0] model [32];

    mips_register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .read1_addr(read1_addr),
        .read2_addr(read2_addr),
        .write_addr(write_addr),
        .data_in   (data_in),
        .data_out1 (data_out1),
        .data_out2 (data_out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read port must show: zero in reset or for r0, the write data on
    // a same-cycle write to that address, otherwise the architectural value.
    function automatic logic [31:0] exp_read(input logic r, input logic [4:0] a,
                                             input logic [4:0] wa, input logic [31:0] d);
        if (!r || a == 5'd0) return 32'h0;
        if (wa != 5'd0 && a == wa) return d;
        return model[a];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end

    // Model state update: a clocked write whenever out of reset and addr != 0.
    always @(posedge clk) begin
        if (rst && write_addr != 5'd0) model[write_addr] = data_in;
    end

    // Model reset: asynchronous clear of every register.
    always @(negedge rst) begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_rd1", data_out1, exp_read(rst, read1_addr, write_addr, data_in));
        check("model_rd2", data_out2, exp_read(rst, read2_addr, write_addr, data_in));
    end

    // Drive one cycle of inputs just after the rising edge, then move to
    // just after the falling edge so callers can check before the next write.
    task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] wa, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst        = r;
        read1_addr = a1;
        read2_addr = a2;
        write_addr = wa;
        data_in    = d;
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic        rv;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  wa;
        logic [31:0] d;

        // Reset held across a few edges.
        step(1'b0, 5'd3, 5'd31, 5'd3, 32'hFFFF_FFFF);
        step(1'b0, 5'd3, 5'd31, 5'd3, 32'hFFFF_FFFF);
        check("reset_rd1", data_out1, 32'h0);
        check("reset_rd2", data_out2, 32'h0);

        // Release, then basic write/read.
        step(1'b1, 5'd0, 5'd0, 5'd0, 32'h0);
        step(1'b1, 5'd0, 5'd0, 5'd3,  32'hDEAD_BEEF);
        step(1'b1, 5'd0, 5'd0, 5'd31, 32'h0000_0001);
        step(1'b1, 5'd3, 5'd31, 5'd0, 32'h0);
        check("wr_r3",  data_out1, 32'hDEAD_BEEF);
        check("wr_r31", data_out2, 32'h0000_0001);

        // Zero register ignores writes and never reads non-zero.
        step(1'b1, 5'd0, 5'd3, 5'd0, 32'hFFFF_FFFF);
        check("zero_rd",     data_out1, 32'h0);
        check("zero_r3_ok",  data_out2, 32'hDEAD_BEEF);
        step(1'b1, 5'd0, 5'd31, 5'd0, 32'h0);
        check("zero_after",  data_out1, 32'h0);
        check("zero_r31_ok", data_out2, 32'h0000_0001);

        // Same-cycle bypass on both ports, then the stored value.
        step(1'b1, 5'd7, 5'd7, 5'd7, 32'hCAFE_0007);
        check("bypass_rd1", data_out1, 32'hCAFE_0007);
        check("bypass_rd2", data_out2, 32'hCAFE_0007);
        step(1'b1, 5'd7, 5'd7, 5'd0, 32'h0);
        check("r7_held_rd1", data_out1, 32'hCAFE_0007);
        check("r7_held_rd2", data_out2, 32'hCAFE_0007);

        // Back-to-back writes to the same register.
        step(1'b1, 5'd0, 5'd0, 5'd10, 32'd1);
        step(1'b1, 5'd0, 5'd0, 5'd10, 32'd2);
        step(1'b1, 5'd10, 5'd11, 5'd0, 32'h0);
        check("b2b_r10", data_out1, 32'd2);
        check("b2b_r11", data_out2, 32'd0);

        // Asynchronous reset mid-cycle, observed before any clock edge.
        step(1'b1, 5'd0, 5'd0, 5'd5, 32'h1234_5678);
        step(1'b1, 5'd5, 5'd3, 5'd0, 32'h0);
        check("pre_rst_r5", data_out1, 32'h1234_5678);
        rst = 1'b0;
        #1;
        check("async_rst_r5", data_out1, 32'h0);
        check("async_rst_r3", data_out2, 32'h0);
        step(1'b1, 5'd5, 5'd3, 5'd0, 32'h0);
        check("post_rst_r5", data_out1, 32'h0);
        check("post_rst_r3", data_out2, 32'h0);

        // Sweep: r[i] = i * 0x01010101, then read every pair (i, 31 - i).
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 5'd0, 5'd0, 5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'(i), 5'(31 - i), 5'd0, 32'h0);
            check("sweep_rd1", data_out1, 32'(i) * 32'h0101_0101);
            check("sweep_rd2", data_out2, 32'(31 - i) * 32'h0101_0101);
        end

        // Randomized traffic with occasional bypass hits and reset pulses.
        for (int n = 0; n < 1500; n++) begin
            rv = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 4) == 0) a1 = wa;
            if ($urandom_range(0, 5) == 0) a2 = wa;
            d = 32'($urandom());
            step(rv, a1, a2, wa, d);
        end

        step(1'b1, 5'd0, 5'd0, 5'd0, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
